// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared definitions for the serial transmitter:
//   - state_e     : transmitter FSM states (IDLE / SHIFT / PARITY)
//   - DEF_WIDTH   : default data word width
//   - DEF_CLK_DIV : default clocks per serial bit
// PARITY is only entered when SERIAL_TX_PARITY_EN is defined; the encoding
// is kept in both builds so debug tooling sees the same state values.
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/serial_tx_bit.sv
// -----------------------------------------------------------------------------
// bit_timer
// Divides the system clock into serial bit periods. While enabled, the counter
// runs 0..CLK_DIV-1 and o_tick is high in the cycle the counter sits at
// CLK_DIV-1; the counter wraps to 0 on that same edge.
//
// Ports:
//   clk     in  system clock, rising edge
//   rstn    in  synchronous active-low reset
//   i_clr   in  restart the bit period (asserted when a word is accepted)
//   i_en    in  count enable (high while a frame is on the line)
//   o_tick  out one-cycle pulse at the last clock of each bit period
// -----------------------------------------------------------------------------
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  // A divide-by-1 still needs a 1-bit counter so the vector is never empty.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == DIV_LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Parallel-to-serial transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out LSB-first on sdata, each bit held for
// CLK_DIV clocks, with sframe high for every data (and parity) bit. done
// pulses for one cycle in the first idle cycle after the frame.
//
// Build option: define SERIAL_TX_PARITY_EN to append one even-parity bit
// (XOR of the data bits) after the data bits.
//
// Handshake: a word is transferred on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; in_valid and in_data are ignored otherwise,
// and in_data is sampled only on the transfer edge.
//
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   synchronous active-low reset
//   in_data      in   [WIDTH] word to transmit
//   in_valid     in   in_data valid
//   in_ready     out  block can accept a word
//   sdata        out  serial data, LSB first
//   sframe       out  high while a data/parity bit is on sdata
//   done         out  one-cycle pulse after the last bit of a frame
//   o_dbg_state  out  current FSM state
// -----------------------------------------------------------------------------
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             done,
  output state_e           o_dbg_state
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_idx;
  logic             r_sframe;
  logic             r_in_ready;
  logic             r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_xfer;
  logic             w_busy;
  logic             w_tick;

  assign w_xfer = in_valid && r_in_ready;
  assign w_busy = (r_state != IDLE);

  bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_xfer),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  // sdata is bit 0 of the shift register in every state: the register is
  // all-zero in IDLE, holds the data in SHIFT, and holds only the parity bit
  // in PARITY. This keeps sdata a plain register output.
  assign sdata       = r_shift[0];
  assign sframe      = r_sframe;
  assign in_ready    = r_in_ready;
  assign done        = r_done;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_sframe   <= 1'b0;
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shift    <= in_data;
            r_idx      <= '0;
            r_sframe   <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
`ifdef SERIAL_TX_PARITY_EN
            r_par      <= ^in_data;
`endif
          end
        end

        SHIFT: begin
          if (w_tick) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              // Data is exhausted; park the parity bit where sdata reads.
              r_shift <= {{(WIDTH-1){1'b0}}, r_par};
              r_state <= PARITY;
`else
              // After WIDTH shifts the register is empty, so sdata drops to 0.
              r_shift    <= {1'b0, r_shift[WIDTH-1:1]};
              r_sframe   <= 1'b0;
              r_in_ready <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= IDLE;
`endif
            end else begin
              r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            end
          end
        end

        PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
          if (w_tick) begin
            r_shift    <= '0;
            r_sframe   <= 1'b0;
            r_in_ready <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= IDLE;
          end
`else
          // Unreachable in this build; recover to a clean idle line.
          r_shift    <= '0;
          r_sframe   <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
`endif
        end

        default: begin
          r_shift    <= '0;
          r_sframe   <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first on a single serial line, each bit held for CLK_DIV clocks. It is the transmit end of the team's serial link, pairing with a serial-in/parallel-out receiver that samples `sdata` while `sframe` is high. An optional even-parity bit follows the data bits.

## Interface

Parameters:
- `WIDTH`, default 8: data word width, ≥2.
- `CLK_DIV`, default 4: clocks per serial bit, ≥1.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rstn`  input  1  reset, synchronous, active-low.
- `in_data`  input  WIDTH  word to transmit.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  block can accept a word.
- `sdata`  output  1  serial data, LSB first.
- `sframe`  output  1  high for every cycle a data or parity bit is on `sdata`.
- `done`  output  1  one-cycle pulse after the last bit of a frame.

## Operation

- States: IDLE, SHIFT, PARITY (only when parity is compiled in).
- IDLE: `in_ready`=1, `sdata`=0, `sframe`=0. Transfer occurs on a rising edge with `in_valid`&&`in_ready`. It loads the shift register with `in_data`, clears the bit index and divider, and moves to SHIFT.
- SHIFT: `sdata`=shift register bit 0, `sframe`=1, `in_ready`=0. A divider counts 0..CLK_DIV-1 and a bit tick is generated at CLK_DIV-1.
  - On each tick the register shifts right and the bit index increments.
  - On the tick of bit WIDTH-1, the FSM goes to PARITY if enabled, else to IDLE with `done`=1 for one cycle.
- PARITY: `sdata`=XOR of the captured word, `sframe`=1, held for CLK_DIV cycles, then IDLE with `done` pulse.
- `in_valid` is ignored while not in IDLE. `in_data` is sampled only at transfer, so later changes have no effect.
- Bit index is $clog2(WIDTH+1) bits wide and the divider is $clog2(CLK_DIV) bits wide (minimum 1). The divider wraps to 0 on every tick.
- Reset (any state, any cycle) is applied at the next rising edge with `rstn`=0:
  - state becomes IDLE, shift register, index and divider are cleared, and any frame in progress is abandoned;
  - `sdata`=0, `sframe`=0, `done`=0, `in_ready`=1 after that edge;
  - handshakes are not accepted while `rstn`=0.

## Timing

- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Transfer at edge E: `sframe` rises and bit 0 appears in the cycle after E. Bit k occupies cycles E+1+k·CLK_DIV … E+(k+1)·CLK_DIV.
- Without parity, `sframe` is high for exactly WIDTH·CLK_DIV cycles. With parity it is high for (WIDTH+1)·CLK_DIV cycles.
- The `done` cycle is the first IDLE cycle, so `in_ready`=1 in the same cycle. A word offered then is transferred at the end of that cycle, which gives exactly one idle cycle between back-to-back frames.
- With CLK_DIV=1, a bit tick occurs every cycle and each bit lasts one cycle.

## Configuration

- Macro `SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state exists, one even-parity bit (XOR of the WIDTH data bits) is appended, and the frame is WIDTH+1 bits.
- Undefined: no PARITY state or logic, and the frame is WIDTH bits.
- The handshake and `done` timing rules are the same in both builds.

## Structure

- Package `serial_tx_pkg`: the state enum typedef (IDLE/SHIFT/PARITY) and the default constants for WIDTH and CLK_DIV.
- Sub-module `bit_timer`:
  - inputs: `clk`, `rstn`, and a clear that is asserted at transfer;
  - output: a one-cycle `tick` every CLK_DIV cycles while enabled.
- The top level holds the FSM, shift register, bit index and parity register.

## Test plan

- WIDTH=8, CLK_DIV=4, send 0xA5:
  - `sdata`=1,0,1,0,0,1,0,1, each bit 4 cycles;
  - `sframe` high 32 cycles;
  - `done` pulses 33 cycles after transfer, with `in_ready`=1 in the same cycle.
- Parity build, send 0xA5 then 0x07 back-to-back:
  - the parity bit is 0 for 0xA5 and 1 for 0x07;
  - `sframe` is high 36 cycles per frame;
  - there is exactly 1 idle cycle between frames.
- Hold `in_valid`=1 with changing `in_data` during a frame:
  - no second capture occurs;
  - the transmitted bits match the word present at transfer.
- Assert `rstn`=0 at bit 3 of 0xFF:
  - after the next edge, `sframe`=0, `sdata`=0, `done`=0 and `in_ready`=1;
  - no `done` pulse occurs;
  - a following send of 0x01 transmits correctly.
- CLK_DIV=1, WIDTH=4, send 0xC:
  - `sdata`=0,0,1,1 on 4 consecutive cycles;
  - `done` appears on cycle 5 after transfer.
